ysyx_220066_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the ysyx_220066 EX stage, replacing the single-cycle dummy multiplier. Executes all RV64M operations (including W variants) over multiple cycles behind a valid/ready handshake. The EX stage stalls its pipeline register while the unit is busy, and flushes it on `raise_intr`.

---
 rtl/ysyx_220066_pkg.sv | 19 +
 rtl/ysyx_220066_mdu_div.sv | 29 ++
 rtl/ysyx_220066_mdu.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_220066_mdu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the ysyx_220066 EX stage and its multiply/divide unit.
package ysyx_220066_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ysyx_220066_mdu_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the quotient bit in.
module ysyx_220066_mdu_div #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_i};
        // On a borrow the shifted remainder is below the divisor, so its top bit is zero.
        if (diff[XLEN+1]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ysyx_220066_mdu.sv
// Iterative RV64M multiply/divide unit: magnitude shift-add multiplier and
// restoring divider sharing one FSM, with sign fix-up on the way into DONE.
module ysyx_220066_mdu
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      op,
    input  logic            is_w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              is_w_q, is_w_d, neg_q, neg_d, rneg_q, rneg_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x, input logic sgn);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & x[31];
        return r;
    endfunction

    logic             sgn1, sgn2, neg1, neg2, div0, ovf;
    logic [XLEN-1:0]  ext1, ext2, mag1, mag2, min_val, fast_res;
    logic [CNT_W-1:0] div_steps, mul_steps;

    always_comb begin
        sgn1 = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
        sgn2 = sgn1 && (op != MDU_MULHSU);
        ext1 = is_w ? sext32(src1, sgn1) : src1;
        ext2 = is_w ? sext32(src2, sgn2) : src2;
        neg1 = sgn1 && ext1[XLEN-1];
        neg2 = sgn2 && ext2[XLEN-1];
        mag1 = neg1 ? -ext1 : ext1;
        mag2 = neg2 ? -ext2 : ext2;
        min_val = is_w ? sext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div0 = op[2] && (ext2 == '0);
        ovf  = op[2] && !op[0] && (ext1 == min_val) && (ext2 == '1);
        if (div0) fast_res = op[1] ? ext1 : '1;
        else      fast_res = op[1] ? '0 : ext1;
        if (is_w) fast_res = sext32(fast_res, 1'b1);
        div_steps = is_w ? CNT_W'(32) : CNT_W'(XLEN);
        mul_steps = is_w ? CNT_W'(32 / MUL_BITS) : CNT_W'(XLEN / MUL_BITS);
    end

    logic [XLEN+MUL_BITS-1:0] psum;
    logic [2*XLEN-1:0]        prod, prod_s;
    logic [XLEN-1:0]          lo_w, mul_res, quo_n, rem_n, div_res;

    ysyx_220066_mdu_div #(.XLEN(XLEN)) u_div (
        .rem_i (acc_q[XLEN-1:0]),
        .quo_i (b_q),
        .dvs_i (a_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    // The accumulator shifts right MUL_BITS per step, so a W=32 product ends
    // up left-aligned at bit XLEN-32 rather than at bit 0.
    always_comb begin
        psum = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
               ({{MUL_BITS{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[MUL_BITS-1:0]});
        prod   = {psum, acc_q[XLEN-1:MUL_BITS]};
        prod_s = neg_q ? -prod : prod;
        lo_w   = '0;
        lo_w[31:0] = prod_s[XLEN-1 -: 32];
        if (is_w_q)                mul_res = sext32(lo_w, 1'b1);
        else if (op_q == MDU_MUL)  mul_res = prod_s[XLEN-1:0];
        else                       mul_res = prod_s[2*XLEN-1:XLEN];
        div_res = op_q[1] ? (rneg_q ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
        if (is_w_q) div_res = sext32(div_res, 1'b1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        is_w_d      = is_w_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d   = op;
                is_w_d = is_w;
                neg_d  = neg1 ^ neg2;
                rneg_d = neg1;
                a_d    = op[2] ? mag2 : mag1;
                b_d    = op[2] ? (is_w ? mag1 << (XLEN - 32) : mag1) : mag2;
                acc_d  = '0;
                if (div0 || ovf) begin
                    state_d     = DONE;
                    result_d    = fast_res;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    state_d = CALC;
                    cnt_d   = op[2] ? div_steps : mul_steps;
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = {{XLEN{1'b0}}, rem_n};
                    b_d   = quo_n;
                end else begin
                    acc_d = prod;
                    b_d   = b_q >> MUL_BITS;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = op_q[2] ? div_res : mul_res;
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            is_w_q      <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            is_w_q      <= is_w_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_220066_mdu.sv
// Scoreboard bench for the MDU: directed ops push expected result and first-valid
// cycle; per-instance monitors pop and compare when out_valid appears.
module tb_ysyx_220066_mdu;
    import ysyx_220066_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b1, is_w = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] src1 = '0, src2 = '0;
    logic        in_ready, in_ready4, out_valid, out_valid4;
    logic [63:0] result, result4;

    ysyx_220066_mdu #(.XLEN(64), .MUL_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .op(op), .is_w(is_w),
        .out_valid(out_valid), .out_ready(out_ready), .result(result));

    ysyx_220066_mdu #(.XLEN(64), .MUL_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
        .src1(src1), .src2(src2), .op(op), .is_w(is_w),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] res; int due; } exp_t;
    exp_t  q1[$], q4[$];
    string n1[$], n4[$];
    int    n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    bit    seen1 = 0, ok1 = 0, seen4 = 0, ok4 = 0;
    exp_t  cur1, cur4;
    string nm1 = "", nm4 = "";

    always @(negedge clk) if (!rst) begin
        if (out_valid) begin
            if (!seen1) begin
                seen1 = 1;
                if (q1.size() == 0) begin
                    chk("unexpected_valid", 64'(out_valid), 64'd0);
                    ok1 = 0;
                end else begin
                    cur1 = q1.pop_front();
                    nm1  = n1.pop_front();
                    ok1  = 1;
                    chk({nm1, "_latency"}, 64'(cyc), 64'(cur1.due));
                end
            end
            if (ok1) chk(nm1, result, cur1.res);
            if (out_ready || flush) seen1 = 0;
        end
    end

    always @(negedge clk) if (!rst) begin
        if (out_valid4) begin
            if (!seen4) begin
                seen4 = 1;
                if (q4.size() == 0) begin
                    chk("unexpected_valid4", 64'(out_valid4), 64'd0);
                    ok4 = 0;
                end else begin
                    cur4 = q4.pop_front();
                    nm4  = n4.pop_front();
                    ok4  = 1;
                    chk({nm4, "_latency"}, 64'(cyc), 64'(cur4.due));
                end
            end
            if (ok4) chk(nm4, result4, cur4.res);
            if (out_ready || flush) seen4 = 0;
        end
    end

    // lat = edges after the accepting edge until out_valid is seen.
    task automatic issue(input bit on4, input string name, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int lat, input bit sb);
        int   t = 0;
        exp_t e;
        while (!(on4 ? in_ready4 : in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk({name, "_ready_timeout"}, 64'(on4 ? in_ready4 : in_ready), 64'd1);
        op = o; is_w = w; src1 = a; src2 = b;
        if (on4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        if (sb) begin
            e.res = exp;
            e.due = cyc + lat;
            if (on4) begin q4.push_back(e); n4.push_back(name); end
            else     begin q1.push_back(e); n1.push_back(name); end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q4.size() != 0 || out_valid || out_valid4) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) chk("drain_timeout", 64'(q1.size() + q4.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid4", 64'(out_valid4), 64'd0);
        chk("rst_result4", result4, 64'd0);
        chk("rst_in_ready4", 64'(in_ready4), 64'd1);

        issue(1, "mul4_3x-5", MDU_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 16, 1);
        drain();
        issue(0, "mul_3x-5", MDU_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 64, 1);
        issue(0, "mulh_m1", MDU_MULH, 0, '1, '1, 64'h0, 64, 1);
        issue(0, "mulhu_m1", MDU_MULHU, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1);
        issue(0, "mulhsu_m1", MDU_MULHSU, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1);
        issue(0, "div_by0", MDU_DIV, 0, 64'd7, 64'd0, '1, 0, 1);
        issue(0, "remu_by0", MDU_REMU, 0, 64'd7, 64'd0, 64'd7, 0, 1);
        issue(0, "div_ovf", MDU_DIV, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 1);
        issue(0, "rem_ovf", MDU_REM, 0, 64'h8000_0000_0000_0000, '1, 64'h0, 0, 1);
        issue(0, "div_-7_2", MDU_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1);
        issue(0, "rem_-7_2", MDU_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1);
        issue(0, "divu_100_7", MDU_DIVU, 0, 64'd100, 64'd7, 64'd14, 64, 1);
        issue(0, "remu_100_7", MDU_REMU, 0, 64'd100, 64'd7, 64'd2, 64, 1);
        issue(0, "divuw", MDU_DIVU, 1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32, 1);
        issue(0, "mulw", MDU_MUL, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 1);
        issue(0, "divw_-7_2", MDU_DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1);
        issue(0, "remw_-7_2", MDU_REM, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1);
        drain();

        // Flush in the tenth CALC cycle of a divide; that result must never appear.
        issue(0, "div_flushed", MDU_DIV, 0, 64'd100, 64'd7, 64'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (80) @(posedge clk);
        #1;
        issue(0, "divu_after_flush", MDU_DIVU, 0, 64'd1000, 64'd10, 64'd100, 64, 1);
        drain();

        // Backpressure on a fast-path result.
        out_ready = 1'b0;
        issue(0, "bp_div0", MDU_DIV, 0, 64'd7, 64'd0, '1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
